// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX hazard sources in, per-stage
// bubble/flush controls and performance counters out.
interface hazard_ctrl_if;
  logic [4:0]  reg1_srcD;
  logic [4:0]  reg2_srcD;
  logic [4:0]  reg_dstE;
  logic        load_E;
  logic        div_start_E;
  logic        br_taken_E;
  logic        jalr_E;
  logic        jal_D;
  logic        dcache_miss;

  logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic        div_busy;
  logic [31:0] perf_miss_cyc;
  logic [31:0] perf_div_cyc;
  logic [31:0] perf_flush_cnt;

  modport master (
    output reg1_srcD, reg2_srcD, reg_dstE, load_E, div_start_E,
           br_taken_E, jalr_E, jal_D, dcache_miss,
    input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushF, flushD, flushE, flushM, flushW, div_busy,
           perf_miss_cyc, perf_div_cyc, perf_flush_cnt
  );

  modport slave (
    input  reg1_srcD, reg2_srcD, reg_dstE, load_E, div_start_E,
           br_taken_E, jalr_E, jal_D, dcache_miss,
    output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
           flushF, flushD, flushE, flushM, flushW, div_busy,
           perf_miss_cyc, perf_div_cyc, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: miss, divide, load-use and
// control-transfer hazards. Optional perf counters: HAZARD_PERF_CNT_EN.
//
// state | meaning
// RUN   | normal issue; a divide entering EX stalls here and moves to DIV
// DIV   | divide occupying EX; cnt counts cycles until the release cycle
module hazard_ctrl #(
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 8
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);

  typedef enum logic {S_RUN, S_DIV} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic b_f, b_d, b_e, b_m, b_w;
  logic f_f, f_d, f_e, f_m, f_w;
  logic load_use;

  assign load_use = hif.load_E && (hif.reg_dstE != 5'd0) &&
                    ((hif.reg_dstE == hif.reg1_srcD) ||
                     (hif.reg_dstE == hif.reg2_srcD));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    b_f = 1'b0; b_d = 1'b0; b_e = 1'b0; b_m = 1'b0; b_w = 1'b0;
    f_f = 1'b0; f_d = 1'b0; f_e = 1'b0; f_m = 1'b0; f_w = 1'b0;
    if (rst) begin
      f_f = 1'b1; f_d = 1'b1; f_e = 1'b1; f_m = 1'b1; f_w = 1'b1;
    end else if (hif.dcache_miss) begin
      // Everything up to MEM freezes; pending branches retry after the miss.
      b_f = 1'b1; b_d = 1'b1; b_e = 1'b1; b_m = 1'b1;
      f_w = 1'b1;
    end else if (state == S_DIV) begin
      if (cnt < CNT_LAST) begin
        b_f = 1'b1; b_d = 1'b1; b_e = 1'b1;
        f_m = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
      end else begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
        f_d       = hif.jal_D;
      end
    end else if (hif.div_start_E) begin
      b_f = 1'b1; b_d = 1'b1; b_e = 1'b1;
      f_m = 1'b1;
      state_nxt = S_DIV;
      cnt_nxt   = CNT_W'(1);
    end else if (hif.br_taken_E || hif.jalr_E) begin
      f_d = 1'b1; f_e = 1'b1;
    end else if (load_use) begin
      b_f = 1'b1; b_d = 1'b1;
      f_e = 1'b1;
    end else if (hif.jal_D) begin
      f_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign hif.bubbleF  = b_f;
  assign hif.bubbleD  = b_d;
  assign hif.bubbleE  = b_e;
  assign hif.bubbleM  = b_m;
  assign hif.bubbleW  = b_w;
  assign hif.flushF   = f_f;
  assign hif.flushD   = f_d;
  assign hif.flushE   = f_e;
  assign hif.flushM   = f_m;
  assign hif.flushW   = f_w;
  assign hif.div_busy = !rst && (state == S_DIV);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] miss_cyc_q, div_cyc_q, flush_cnt_q;
  logic        ev_miss, ev_div, ev_flush;

  assign ev_miss  = hif.dcache_miss;
  assign ev_div   = !hif.dcache_miss &&
                    ((state == S_DIV) ? (cnt < CNT_LAST) : hif.div_start_E);
  // Only branch/JALR/JAL flushes from RUN count; the release-cycle JAL does not.
  assign ev_flush = !hif.dcache_miss && (state == S_RUN) && !hif.div_start_E &&
                    (hif.br_taken_E || hif.jalr_E || (!load_use && hif.jal_D));

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_cyc_q  <= '0;
      div_cyc_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ev_miss)  miss_cyc_q  <= miss_cyc_q + 32'd1;
      if (ev_div)   div_cyc_q   <= div_cyc_q + 32'd1;
      if (ev_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hif.perf_miss_cyc  = miss_cyc_q;
  assign hif.perf_div_cyc   = div_cyc_q;
  assign hif.perf_flush_cnt = flush_cnt_q;
`else
  assign hif.perf_miss_cyc  = 32'd0;
  assign hif.perf_div_cyc   = 32'd0;
  assign hif.perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (DIV_LATENCY=8); perf counters are
// checked against live values with HAZARD_PERF_CNT_EN, else against zero.
module tb_hazard_ctrl;

  localparam logic [9:0] BF = 10'h200, BD = 10'h100, BE = 10'h080,
                         BM = 10'h040, BW = 10'h020, FF = 10'h010,
                         FD = 10'h008, FE = 10'h004, FM = 10'h002,
                         FW = 10'h001;
  localparam logic [9:0] ALL_FL  = FF | FD | FE | FM | FW;
  localparam logic [9:0] DSTALL  = BF | BD | BE | FM;
  localparam logic [9:0] MSTALL  = BF | BD | BE | BM | FW;
  localparam logic [9:0] LUSTALL = BF | BD | FE;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [10:0] exp_q[$];

  hazard_ctrl_if hif ();

  hazard_ctrl #(.DIV_LATENCY(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    hif.reg1_srcD = 5'd0; hif.reg2_srcD = 5'd0; hif.reg_dstE = 5'd0;
    hif.load_E = 1'b0; hif.div_start_E = 1'b0; hif.br_taken_E = 1'b0;
    hif.jalr_E = 1'b0; hif.jal_D = 1'b0; hif.dcache_miss = 1'b0;
  endtask

  // Expectation is queued with the stimulus, retired at the following negedge.
  task automatic step(input string tag, input logic [9:0] exp_o, input logic exp_busy);
    logic [10:0] e;
    logic [9:0]  obs;
    exp_q.push_back({exp_busy, exp_o});
    @(negedge clk);
    obs = {hif.bubbleF, hif.bubbleD, hif.bubbleE, hif.bubbleM, hif.bubbleW,
           hif.flushF, hif.flushD, hif.flushE, hif.flushM, hif.flushW};
    if (exp_q.size() == 0) begin
      chk({tag, "/sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/ctl"}, {22'd0, obs}, {22'd0, e[9:0]});
      chk({tag, "/busy"}, {31'd0, hif.div_busy}, {31'd0, e[10]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string tag, input int m, input int d, input int f);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, "/perf_miss"},  hif.perf_miss_cyc,  m);
    chk({tag, "/perf_div"},   hif.perf_div_cyc,   d);
    chk({tag, "/perf_flush"}, hif.perf_flush_cnt, f);
`else
    if (m + d + f < 0) $display("negative perf expectation in %s", tag);
    chk({tag, "/perf_miss"},  hif.perf_miss_cyc,  32'd0);
    chk({tag, "/perf_div"},   hif.perf_div_cyc,   32'd0);
    chk({tag, "/perf_flush"}, hif.perf_flush_cnt, 32'd0);
`endif
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step("rst0", ALL_FL, 1'b0);
    step("rst1", ALL_FL, 1'b0);
    rst = 1'b0;
    step("idle", 10'd0, 1'b0);
    check_perf("post_rst", 0, 0, 0);

    // load-use on rs1, rs2, x0 and a non-matching destination
    hif.load_E = 1'b1; hif.reg_dstE = 5'd5; hif.reg1_srcD = 5'd5;
    step("lu_rs1", LUSTALL, 1'b0);
    hif.reg1_srcD = 5'd3; hif.reg2_srcD = 5'd5;
    step("lu_rs2", LUSTALL, 1'b0);
    hif.reg_dstE = 5'd0; hif.reg1_srcD = 5'd0; hif.reg2_srcD = 5'd0;
    step("lu_x0", 10'd0, 1'b0);
    hif.reg_dstE = 5'd5; hif.reg1_srcD = 5'd6; hif.reg2_srcD = 5'd7;
    step("lu_nomatch", 10'd0, 1'b0);
    hif.load_E = 1'b0; hif.reg1_srcD = 5'd5;
    step("lu_noload", 10'd0, 1'b0);
    idle();

    // plain divide: 7 stall cycles, release on the 8th
    hif.div_start_E = 1'b1;
    step("div_enter", DSTALL, 1'b0);
    for (int i = 1; i < 7; i++) step("div_stall", DSTALL, 1'b1);
    step("div_release", 10'd0, 1'b1);
    hif.div_start_E = 1'b0;
    step("div_done", 10'd0, 1'b0);
    check_perf("div", 0, 7, 0);

    // miss arrives at cnt=3 and freezes the divide for 3 cycles
    hif.div_start_E = 1'b1;
    step("dm_enter", DSTALL, 1'b0);
    step("dm_c1", DSTALL, 1'b1);
    step("dm_c2", DSTALL, 1'b1);
    hif.dcache_miss = 1'b1;
    for (int i = 0; i < 3; i++) step("dm_miss", MSTALL, 1'b1);
    hif.dcache_miss = 1'b0;
    for (int i = 0; i < 4; i++) step("dm_resume", DSTALL, 1'b1);
    step("dm_release", 10'd0, 1'b1);
    hif.div_start_E = 1'b0;
    step("dm_done", 10'd0, 1'b0);
    check_perf("div_miss", 3, 14, 0);

    // taken branch held under a miss takes effect right after it
    hif.dcache_miss = 1'b1; hif.br_taken_E = 1'b1;
    step("brm_miss0", MSTALL, 1'b0);
    step("brm_miss1", MSTALL, 1'b0);
    hif.dcache_miss = 1'b0;
    step("brm_flush", FD | FE, 1'b0);
    hif.br_taken_E = 1'b0;
    step("brm_idle", 10'd0, 1'b0);
    check_perf("br_miss", 5, 14, 1);

    // load-use outranks JAL; JAL flushes one cycle later
    hif.load_E = 1'b1; hif.reg_dstE = 5'd9; hif.reg2_srcD = 5'd9; hif.jal_D = 1'b1;
    step("lujal_c1", LUSTALL, 1'b0);
    hif.load_E = 1'b0;
    step("lujal_c2", FD, 1'b0);
    idle();
    hif.jalr_E = 1'b1;
    step("jalr", FD | FE, 1'b0);
    idle();
    step("jalr_idle", 10'd0, 1'b0);
    check_perf("jal", 5, 14, 3);

    // miss and divide start together: miss first, DIV entry deferred
    hif.dcache_miss = 1'b1; hif.div_start_E = 1'b1;
    step("md_miss", MSTALL, 1'b0);
    hif.dcache_miss = 1'b0;
    step("md_enter", DSTALL, 1'b0);
    for (int i = 1; i < 7; i++) step("md_stall", DSTALL, 1'b1);
    check_perf("md", 6, 21, 3);
    hif.jal_D = 1'b1;
    step("md_release_jal", FD, 1'b1);
    idle();
    step("md_done", 10'd0, 1'b0);

    // reset in the middle of a divide
    hif.div_start_E = 1'b1;
    step("rd_enter", DSTALL, 1'b0);
    step("rd_stall", DSTALL, 1'b1);
    rst = 1'b1;
    step("rd_rst", ALL_FL, 1'b0);
    rst = 1'b0;
    idle();
    step("rd_after", 10'd0, 1'b0);
    check_perf("rd", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
